// File: rtl/mvu_xbar_pkg.sv
// Shared constants and packed-bus slice helper for the MVU crossbar.
package mvu_xbar_pkg;

   localparam int DEF_NMVU  = 8;
   localparam int DEF_W     = 64;
   localparam int DEF_DEPTH = 4;

   // Element idx of a packed per-MVU bus starts at bit lo(idx, width).
   function automatic int lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/mvu_xbar_if.sv
// Send/receive/config bundle between the MVU array and the crossbar.
interface mvu_xbar_if #(
   parameter int NMVU  = 8,
   parameter int W     = 64,
   parameter int DEPTH = 4
);
   localparam int BA = $clog2(NMVU);
   localparam int BC = $clog2(DEPTH + 1);

   logic [NMVU-1:0]    cfg_we;
   logic [NMVU-1:0]    cfg_on;
   logic [NMVU*BA-1:0] cfg_from;

   // Handshake: a sender word transfers on a rising edge where
   // send_en[s] && send_rdy[s]; a receiver head pops on an edge where
   // recv_en[r] && recv_ack[r]. recv_ack with recv_en low is ignored.
   logic [NMVU-1:0]    send_en;
   logic [NMVU*W-1:0]  send_word;
   logic [NMVU-1:0]    send_rdy;
   logic [NMVU-1:0]    recv_en;
   logic [NMVU*W-1:0]  recv_word;
   logic [NMVU-1:0]    recv_ack;
   logic [NMVU*BC-1:0] recv_cnt;

   modport master (
      output cfg_we, cfg_on, cfg_from, send_en, send_word, recv_ack,
      input  send_rdy, recv_en, recv_word, recv_cnt
   );

   modport slave (
      input  cfg_we, cfg_on, cfg_from, send_en, send_word, recv_ack,
      output send_rdy, recv_en, recv_word, recv_cnt
   );
endinterface

// File: rtl/mvu_xbar_fifo.sv
// Show-ahead circular FIFO for one crossbar receiver; head reads as 0 when empty.
module mvu_xbar_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         push,
   input  logic [W-1:0]                 din,
   input  logic                         pop,
   output logic [W-1:0]                 dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int BC = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          push_ok, pop_ok;

   // Extra pointer bit distinguishes full from empty when addresses match.
   assign count   = BC'(wr_ptr - rd_ptr);
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (count == BC'(DEPTH));
   assign push_ok = push && !full && !clr;
   assign pop_ok  = pop && !empty && !clr;
   assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mvu_xbar.sv
// Buffered multicast crossbar: per-receiver route registers and FIFOs,
// with each sender stalled until every listener has room.
module mvu_xbar
   import mvu_xbar_pkg::*;
#(
   parameter int NMVU  = DEF_NMVU,
   parameter int W     = DEF_W,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      clr,
   mvu_xbar_if.slave bus
);
   localparam int BA = $clog2(NMVU);
   localparam int BC = $clog2(DEPTH + 1);

   logic [NMVU-1:0] route_on;
   logic [BA-1:0]   route_from [NMVU];
   logic [NMVU-1:0] listen [NMVU];   // listen[s][r]
   logic [NMVU-1:0] full_a, empty_a, push, accept, rdy;
   logic [W-1:0]    word_a [NMVU];
   logic [BC-1:0]   cnt_a  [NMVU];

   // full is register-derived, so recv_ack never reaches send_rdy combinationally.
   always_comb begin
      rdy = '1;
      for (int s = 0; s < NMVU; s++) begin
         listen[s] = '0;
         for (int r = 0; r < NMVU; r++)
            listen[s][r] = route_on[r] && (route_from[r] == BA'(s));
         rdy[s] = ~|(listen[s] & full_a);
      end
   end

   assign accept       = bus.send_en & rdy;
   assign bus.send_rdy = rdy;

   always_comb begin
      push = '0;
      for (int r = 0; r < NMVU; r++)
         push[r] = route_on[r] && accept[route_from[r]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         route_on <= '0;
         for (int r = 0; r < NMVU; r++) route_from[r] <= '0;
      end else if (clr) begin
         route_on <= '0;
      end else begin
         for (int r = 0; r < NMVU; r++) begin
            if (bus.cfg_we[r]) begin
               route_on[r]   <= bus.cfg_on[r];
               route_from[r] <= bus.cfg_from[lo(r, BA) +: BA];
            end
         end
      end
   end

   for (genvar g = 0; g < NMVU; g++) begin : g_rx
      logic [W-1:0] din;
      assign din = bus.send_word[int'(route_from[g]) * W +: W];

      mvu_xbar_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (clr),
         .push  (push[g]),
         .din   (din),
         .pop   (bus.recv_ack[g]),
         .dout  (word_a[g]),
         .full  (full_a[g]),
         .empty (empty_a[g]),
         .count (cnt_a[g])
      );
   end

   always_comb begin
      bus.recv_en   = '0;
      bus.recv_word = '0;
      bus.recv_cnt  = '0;
      for (int r = 0; r < NMVU; r++) begin
         bus.recv_en[r]                = !empty_a[r];
         bus.recv_word[lo(r, W) +: W]  = word_a[r];
         bus.recv_cnt[lo(r, BC) +: BC] = cnt_a[r];
      end
   end

endmodule

// File: tb/tb_mvu_xbar.sv
// Directed bench for mvu_xbar: queue-per-receiver model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_mvu_xbar;
   localparam int NMVU  = 8;
   localparam int W     = 64;
   localparam int DEPTH = 4;
   localparam int BA    = $clog2(NMVU);
   localparam int BC    = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst_n;
   logic clr;

   mvu_xbar_if #(.NMVU(NMVU), .W(W), .DEPTH(DEPTH)) bus ();

   mvu_xbar #(.NMVU(NMVU), .W(W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [W-1:0] exp_q [NMVU][$];
   bit           m_on   [NMVU];
   int           m_from [NMVU];
   logic [NMVU-1:0] m_rdy;

   function automatic logic [NMVU-1:0] model_rdy();
      logic [NMVU-1:0] v = '1;
      for (int s = 0; s < NMVU; s++)
         for (int r = 0; r < NMVU; r++)
            if (m_on[r] && m_from[r] == s && exp_q[r].size() == DEPTH) v[s] = 1'b0;
      return v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NMVU; r++) begin
            exp_q[r].delete();
            m_on[r]   = 1'b0;
            m_from[r] = 0;
         end
      end else begin
         m_rdy = model_rdy();
         if (clr) begin
            for (int r = 0; r < NMVU; r++) begin
               exp_q[r].delete();
               m_on[r] = 1'b0;
            end
         end else begin
            for (int r = 0; r < NMVU; r++)
               if (bus.recv_ack[r] && exp_q[r].size() > 0) void'(exp_q[r].pop_front());
            for (int s = 0; s < NMVU; s++)
               if (bus.send_en[s] && m_rdy[s])
                  for (int r = 0; r < NMVU; r++)
                     if (m_on[r] && m_from[r] == s) exp_q[r].push_back(bus.send_word[s*W +: W]);
            for (int r = 0; r < NMVU; r++)
               if (bus.cfg_we[r]) begin
                  m_on[r]   = bus.cfg_on[r];
                  m_from[r] = int'(bus.cfg_from[r*BA +: BA]);
               end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [W-1:0] got1 [$];

   always @(negedge clk) begin
      check("send_rdy", W'(bus.send_rdy), W'(model_rdy()));
      for (int r = 0; r < NMVU; r++) begin
         check($sformatf("recv_en[%0d]", r), W'(bus.recv_en[r]), W'(exp_q[r].size() != 0));
         check($sformatf("recv_cnt[%0d]", r), W'(bus.recv_cnt[r*BC +: BC]), W'(exp_q[r].size()));
         check($sformatf("cnt_range[%0d]", r), W'(bus.recv_cnt[r*BC +: BC] <= DEPTH), W'(1));
         if (exp_q[r].size() != 0)
            check($sformatf("recv_word[%0d]", r), bus.recv_word[r*W +: W], exp_q[r][0]);
      end
      if (rst_n && bus.recv_en[1] && bus.recv_ack[1]) got1.push_back(bus.recv_word[1*W +: W]);
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_route(input int r, input bit on, input int from);
      bus.cfg_we               = '0;
      bus.cfg_we[r]            = 1'b1;
      bus.cfg_on[r]            = on;
      bus.cfg_from[r*BA +: BA] = BA'(from);
      tick();
      bus.cfg_we = '0;
   endtask

   task automatic offer(input int s, input logic [W-1:0] w);
      bus.send_en[s]         = 1'b1;
      bus.send_word[s*W +: W] = w;
   endtask

   function automatic logic [W-1:0] cnt(input int r);
      return W'(bus.recv_cnt[r*BC +: BC]);
   endfunction

   function automatic logic [W-1:0] word(input int r);
      return bus.recv_word[r*W +: W];
   endfunction

   logic [W-1:0] rc_exp [4];

   initial begin
      rst_n = 1'b0;
      clr   = 1'b0;
      bus.cfg_we = '0; bus.cfg_on = '0; bus.cfg_from = '0;
      bus.send_en = '0; bus.send_word = '0; bus.recv_ack = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset / idle
      check("rst_send_rdy", W'(bus.send_rdy), W'(8'hFF));
      check("rst_recv_en", W'(bus.recv_en), W'(0));
      check("rst_recv_cnt", W'(bus.recv_cnt), W'(0));
      offer(2, 64'hDEAD);
      tick();
      bus.send_en = '0;
      check("drop_no_route", W'(bus.recv_en), W'(0));

      // unicast r5 <- s2
      set_route(5, 1'b1, 2);
      offer(2, 64'hA5A5);
      check("no_bypass", W'(bus.recv_en[5]), W'(0));
      tick();
      bus.send_en = '0;
      check("uni_en", W'(bus.recv_en[5]), W'(1));
      check("uni_word", word(5), 64'hA5A5);
      bus.recv_ack[5] = 1'b1;
      tick();
      bus.recv_ack = '0;
      check("uni_popped", W'(bus.recv_en[5]), W'(0));

      // multicast r1,r3,r6 <- s0; r3 never acked until released
      set_route(1, 1'b1, 0);
      set_route(3, 1'b1, 0);
      set_route(6, 1'b1, 0);
      bus.recv_ack[1] = 1'b1;
      bus.recv_ack[6] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         offer(0, 64'h100 + 64'(i));
         tick();
      end
      offer(0, 64'h104);
      check("mc_stall", W'(bus.send_rdy[0]), W'(0));
      check("mc_r3_full", cnt(3), 64'd4);
      tick();
      check("mc_still_full", cnt(3), 64'd4);
      bus.recv_ack[3] = 1'b1;
      tick();
      bus.recv_ack[3] = 1'b0;
      check("full_pop_cnt", cnt(3), 64'd3);
      check("mc_release", W'(bus.send_rdy[0]), W'(1));
      tick();
      bus.send_en = '0;
      check("mc_r3_refill", cnt(3), 64'd4);
      repeat (3) tick();
      check("mc_r1_count", W'(got1.size()), 64'd5);
      for (int i = 0; i < 5 && i < got1.size(); i++)
         check($sformatf("mc_r1_word%0d", i), got1[i], 64'h100 + 64'(i));
      bus.recv_ack[3] = 1'b1;
      repeat (4) tick();
      bus.recv_ack = '0;
      check("mc_r3_drained", cnt(3), 64'd0);

      // steady stream on self-route r7 <- s7, wraps pointers
      set_route(7, 1'b1, 7);
      bus.recv_ack[7] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         offer(7, 64'h700 + 64'(i));
         tick();
         check($sformatf("steady_cnt%0d", i), cnt(7), 64'd1);
      end
      bus.send_en = '0;
      tick();
      bus.recv_ack = '0;
      check("steady_drain", cnt(7), 64'd0);

      // route change with words queued: old words drain first
      offer(2, 64'h2A); tick();
      offer(2, 64'h2B); tick();
      bus.send_en = '0;
      set_route(5, 1'b1, 4);
      offer(4, 64'h4A); tick();
      offer(4, 64'h4B); tick();
      bus.send_en = '0;
      rc_exp[0] = 64'h2A; rc_exp[1] = 64'h2B; rc_exp[2] = 64'h4A; rc_exp[3] = 64'h4B;
      check("rc_cnt", cnt(5), 64'd4);
      bus.recv_ack[5] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rc_word%0d", i), word(5), rc_exp[i]);
         tick();
      end
      bus.recv_ack = '0;
      check("rc_empty", W'(bus.recv_en[5]), W'(0));

      // clr wins over same-cycle push and cfg_we
      offer(4, 64'h4C); tick();
      bus.send_en = '0;
      check("clr_pre", cnt(5), 64'd1);
      clr = 1'b1;
      offer(4, 64'h4D);
      bus.cfg_we[5] = 1'b1; bus.cfg_on[5] = 1'b1;
      tick();
      clr = 1'b0; bus.cfg_we = '0;
      check("clr_cnt", W'(bus.recv_cnt), W'(0));
      check("clr_en", W'(bus.recv_en), W'(0));
      offer(4, 64'h4E); tick();
      bus.send_en = '0;
      check("clr_routes_off", W'(bus.recv_en), W'(0));

      // asynchronous reset mid-stream
      set_route(7, 1'b1, 7);
      offer(7, 64'h77); tick(); tick();
      bus.send_en = '0;
      check("pre_rst_cnt", cnt(7), 64'd2);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_en", W'(bus.recv_en), W'(0));
      check("async_rst_cnt", W'(bus.recv_cnt), W'(0));
      check("async_rst_rdy", W'(bus.send_rdy), W'(8'hFF));
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_en", W'(bus.recv_en), W'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mvu_xbar.md
Name: mvu_xbar

Overview:
Buffered, flow-controlled successor to the MVU interconnect. It routes N-bit words read from each MVU's interconnect bank to any set of receiving MVUs (unicast or multicast). Each receiver has a programmable source register and a DEPTH-entry FIFO, with valid/ready backpressure on both sides. It sits between the MVU array's rdi (send) and wri (receive) paths in the top level.

Parameters:
NMVU, 8, number of MVUs (power of 2, >=2)
W, 64, word width in bits (equals MVU N)
DEPTH, 4, per-receiver FIFO entries (power of 2, >=2)
BA (local), $clog2(NMVU), source-index width
BC (local), $clog2(DEPTH+1), occupancy-count width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear: empty all FIFOs, disable all routes
cfg_we  in  NMVU  per-receiver route write strobe
cfg_on  in  NMVU  route enable value written when cfg_we[r]
cfg_from  in  NMVU*BA  source index written when cfg_we[r]; slice r*BA +: BA
send_en  in  NMVU  sender s offers send_word slice s
send_word  in  NMVU*W  sender words; slice s*W +: W
send_rdy  out  NMVU  sender s word accepted this cycle if send_en[s]
recv_en  out  NMVU  receiver r FIFO head valid
recv_word  out  NMVU*W  receiver r FIFO head (show-ahead)
recv_ack  in  NMVU  receiver r pops head; ignored when recv_en[r]=0
recv_cnt  out  NMVU*BC  receiver r FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): all route_on=0, route_from=0, FIFOs empty, recv_en=0, recv_cnt=0, send_rdy=all 1s. recv_word is don't-care, held at 0.
- Routes: registered per receiver. cfg_we[r] latches cfg_on[r]/cfg_from[r] at the clock edge; the new route governs accepts from the next cycle. FIFO contents are retained across route changes.
- Listener set L(s) = {r : route_on[r] && route_from[r]==s}.
- send_rdy[s] = AND over r in L(s) of !full[r], where full is a registered flag. If L(s) is empty, send_rdy[s]=1 and an accepted word is discarded.
- No combinational path from recv_ack to send_rdy. A pop on a full FIFO frees the slot only from the next cycle.
- Accept (send_en[s] && send_rdy[s]) pushes the word into every FIFO in L(s) in the same edge (atomic multicast). It never pushes a partial set.
- Each receiver has exactly one source, so at most one push per FIFO per cycle, with no arbitration.
- Latency: a word accepted at edge k appears at recv_en/recv_word after edge k, i.e. readable in cycle k+1 when the FIFO was empty. No bypass in the same cycle.
- FIFO: circular, pointer width log2(DEPTH)+1, wrap-around at DEPTH.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, head advances.
- Push and pop on an empty FIFO: the push proceeds; the pop is ignored.
- recv_cnt is always in 0..DEPTH. It never overflows or underflows, and the bench asserts this.
- Self-route (route_from[r]==r) is legal and behaves like any other route.
- clr: at the edge, all FIFOs are emptied and all route_on=0. Same-cycle pushes, pops and cfg_we are discarded (clr wins). route_from is retained.
- Reset mid-transfer: in-flight words are lost. The outputs return to their reset values immediately, asynchronously.

Decomposition:
- Shared package/header mvu_pkg: BMVUA computation, default NMVU/W, and the slice-index helper convention for packed per-MVU buses.
- Sub-module xbar_fifo (W, DEPTH): show-ahead FIFO with push/pop/clr, full/empty/count outputs and async active-low reset; instantiated NMVU times.
- The top-level mvu_xbar holds the route registers, listener decode, the send_rdy AND-reduction and the generate loop.

Test Plan:
- Reset then idle: send_rdy=8'hFF, recv_en=0, recv_cnt all 0; send_en[2]=1 with no routes -> word dropped, recv_en stays 0.
- Unicast: route r5<-s2 on; send 0xA5A5 from s2 at edge k -> recv_en[5]=1 and recv_word[5]=0xA5A5 at k+1; recv_ack[5] -> recv_en[5]=0.
- Multicast and backpressure: r1,r3,r6<-s0, DEPTH=4. Push 4 words with r3 never acked -> send_rdy[0]=0 after the 4th. Ack r3 once -> send_rdy[0]=1 the next cycle. r1/r6 receive exactly 5 words in order with no duplicates.
- Full plus simultaneous pop: r3 full with recv_ack[3]=1 and send_en[0]=1 in the same cycle -> push is not accepted, recv_cnt[3] goes 4->3.
- Steady state: a continuous stream with ack every cycle holds recv_cnt steady and preserves data order across pointer wrap-around (20 words).
- Route change and clr: switch r5 from s2 to s4 with 2 words queued -> the old words drain first, then the s4 words follow. Assert clr -> all recv_cnt=0 and route_on=0 next cycle. Assert rst_n=0 mid-stream -> recv_en=0 without waiting for a clock edge.
